sysx_master_v2: RTL and testbench

Second-generation sysX master controller: a host-mapped register block that serialises 32-bit words onto a parallel-lane sysX peripheral bus and collects the returned words. It runs in the host clock domain, deriving the bus clock with an internal divider. It sits between the epRISC host data bus and up to 16 sysX peripherals. Over v1 it adds:
- parametrised lane width, buffer depth and channel count;
- auto-incrementing buffer ports;
- busy, done and error status;
- a maskable completion and peripheral interrupt.

---
 rtl/sysx_pkg.sv | 31 +++
 rtl/sysx_buffer.sv | 23 ++
 rtl/sysx_master_v2.sv | 230 +++++++++++++++++++++++
 tb/tb_sysx_master_v2.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysx_pkg.sv
// rtl/sysx_pkg.sv - shared constants for the sysX master: register map, CONFIG fields, FSM states
package sysx_pkg;

    localparam logic [3:0] ADDR_CONFIG      = 4'd0;
    localparam logic [3:0] ADDR_DIRECT_MOSI = 4'd1;
    localparam logic [3:0] ADDR_DIRECT_MISO = 4'd2;
    localparam logic [3:0] ADDR_MOSI_PTR    = 4'd3;
    localparam logic [3:0] ADDR_MOSI_DATA   = 4'd4;
    localparam logic [3:0] ADDR_MISO_PTR    = 4'd5;
    localparam logic [3:0] ADDR_MISO_DATA   = 4'd6;
    localparam logic [3:0] ADDR_STATUS      = 4'd7;
    localparam logic [3:0] ADDR_IRQ_MASK    = 4'd8;

    localparam int CFG_GO_SINGLE = 0;
    localparam int CFG_GO_BLOCK  = 1;
    localparam int CFG_RX_ONLY   = 2;
    localparam int CFG_DONE_IE   = 3;
    localparam int CFG_CHAN_LSB  = 4;
    localparam int CFG_COUNT_LSB = 8;
    localparam int CFG_STEP_LSB  = 16;

    localparam logic [31:0] BAD_ADDR_DATA = 32'h0BAD_C0DE;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_LOAD  = 2'd1,
        STATE_SHIFT = 2'd2,
        STATE_STORE = 2'd3
    } sysxState_t;

endpackage

// File: rtl/sysx_buffer.sv
// rtl/sysx_buffer.sv - 32-bit simple dual-port RAM, one write port, one synchronous read port
module sysx_buffer #(
    parameter int DEPTH = 256,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          iClock,
    input  logic          iWriteEnable,
    input  logic [PW-1:0] iWriteAddress,
    input  logic [31:0]   iWriteData,
    input  logic [PW-1:0] iReadAddress,
    output logic [31:0]   oReadData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge iClock) begin
        if (iWriteEnable) begin
            mem[iWriteAddress] <= iWriteData;
        end
        oReadData <= mem[iReadAddress];
    end

endmodule

// File: rtl/sysx_master_v2.sv
// rtl/sysx_master_v2.sv - sysX master: host registers, transfer FSM and lane serialiser
// Define SYSX_IRQ_EN to build IRQ_MASK, DONE_IE and the oInterrupt logic.
module sysx_master_v2
    import sysx_pkg::*;
#(
    parameter int LANE_W   = 8,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 4
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic [3:0]          iAddress,
    input  logic                iWrite,
    input  logic                iEnable,
    input  logic [31:0]         iData,
    output logic [31:0]         oData,
    output logic                oInterrupt,
    output logic                oBusClock,
    output logic [LANE_W-1:0]   oBusMOSI,
    input  logic [LANE_W-1:0]   iBusMISO,
    output logic [CHANNELS-1:0] oBusSelect,
    input  logic [CHANNELS-1:0] iBusInterrupt
);

    localparam int BEATS = 32 / LANE_W;
    localparam int PW    = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = STATE_IDLE;
    localparam logic [1:0] LOAD  = STATE_LOAD;
    localparam logic [1:0] SHIFT = STATE_SHIFT;
    localparam logic [1:0] STORE = STATE_STORE;

    logic [1:0]            state;
    logic                  isSingle, rxOnly, doneIe, done, error, busClk;
    logic [3:0]            chan;
    logic [7:0]            count, wordsLeft;
    logic [11:0]           step, divCnt;
    logic                  phaseHigh;
    logic [5:0]            beatCnt;
    logic [31:0]           directMosi, directMiso, txWord, rxWord, dataReg;
    logic [PW-1:0]         mosiPtr, misoPtr, mosiXPtr, misoXPtr, mosiRaddr;
    logic [1:0]            memSel;
    logic [31:0]           mosiRdata, misoRdata, readWord, statusWord, configWord;
    logic [31+LANE_W:0]    rxShifted;
    logic                  busy, hostRead, hostWrite;

    assign busy      = (state != IDLE);
    assign hostWrite = iEnable && iWrite;
    assign hostRead  = iEnable && !iWrite;
    assign rxShifted = {iBusMISO, rxWord};
    assign oBusClock = busClk;

    // The MOSI read port is shared: the host sees MOSI_DATA through it only while idle.
    always_comb begin
        case (state)
            IDLE:    mosiRaddr = mosiPtr;
            STORE:   mosiRaddr = mosiXPtr + 1'b1;
            default: mosiRaddr = mosiXPtr;
        endcase
    end

    sysx_buffer #(.DEPTH(DEPTH), .PW(PW)) mosiBuffer (
        .iClock(iClock), .iWriteEnable(hostWrite && iAddress == ADDR_MOSI_DATA),
        .iWriteAddress(mosiPtr), .iWriteData(iData),
        .iReadAddress(mosiRaddr), .oReadData(mosiRdata)
    );

    sysx_buffer #(.DEPTH(DEPTH), .PW(PW)) misoBuffer (
        .iClock(iClock), .iWriteEnable(state == STORE && !isSingle),
        .iWriteAddress(misoXPtr), .iWriteData(rxWord),
        .iReadAddress(misoPtr), .oReadData(misoRdata)
    );

    always_comb begin
        oBusSelect = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (busy && int'(chan) == i) oBusSelect[i] = 1'b0;
        end
    end

    assign oBusMOSI = (state == SHIFT) ? (rxOnly ? '1 : txWord[LANE_W-1:0]) : '0;

    always_comb begin
        statusWord    = '0;
        statusWord[0] = busy;
        statusWord[1] = done;
        statusWord[2] = error;
`ifdef SYSX_IRQ_EN
        statusWord[8 +: CHANNELS] = iBusInterrupt;
`endif
    end

    assign configWord = {4'd0, step, count, chan, doneIe, rxOnly, busy && !isSingle, busy && isSingle};

`ifdef SYSX_IRQ_EN
    logic [CHANNELS-1:0] irqMask;
    assign oInterrupt = (done && doneIe) || (|(iBusInterrupt & irqMask));
`else
    logic unusedIrq;
    assign unusedIrq  = ^iBusInterrupt;
    assign oInterrupt = 1'b0;
`endif

    always_comb begin
        case (iAddress)
            ADDR_CONFIG:      readWord = configWord;
            ADDR_DIRECT_MOSI: readWord = directMosi;
            ADDR_DIRECT_MISO: readWord = directMiso;
            ADDR_MOSI_PTR:    readWord = 32'(mosiPtr);
            ADDR_MISO_PTR:    readWord = 32'(misoPtr);
            ADDR_MOSI_DATA,
            ADDR_MISO_DATA:   readWord = '0;
            ADDR_STATUS:      readWord = statusWord;
`ifdef SYSX_IRQ_EN
            ADDR_IRQ_MASK:    readWord = 32'(irqMask);
`else
            ADDR_IRQ_MASK:    readWord = '0;
`endif
            default:          readWord = BAD_ADDR_DATA;
        endcase
    end

    // Buffer reads come straight off the RAM register for one cycle, then are held in dataReg.
    assign oData = (memSel == 2'd1) ? mosiRdata : (memSel == 2'd2) ? misoRdata : dataReg;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state <= IDLE;       isSingle <= 1'b0;  rxOnly <= 1'b0;  doneIe <= 1'b0;
            done <= 1'b0;        error <= 1'b0;     busClk <= 1'b1;  chan <= '0;
            count <= '0;         wordsLeft <= '0;   step <= '0;      divCnt <= '0;
            phaseHigh <= 1'b0;   beatCnt <= '0;     directMosi <= '0; directMiso <= '0;
            txWord <= '0;        rxWord <= '0;      dataReg <= '0;   memSel <= '0;
            mosiPtr <= '0;       misoPtr <= '0;     mosiXPtr <= '0;  misoXPtr <= '0;
`ifdef SYSX_IRQ_EN
            irqMask <= '0;
`endif
        end else begin
            if (hostRead) begin
                dataReg <= readWord;
                memSel  <= (iAddress == ADDR_MOSI_DATA) ? 2'd1 : (iAddress == ADDR_MISO_DATA) ? 2'd2 : 2'd0;
                if (iAddress == ADDR_MISO_DATA) misoPtr <= misoPtr + 1'b1;
            end else if (memSel != 2'd0) begin
                dataReg <= oData;
                memSel  <= 2'd0;
            end

            if (hostWrite) begin
                case (iAddress)
                    ADDR_CONFIG: begin
                        if (busy) begin
                            error <= 1'b1;
                        end else begin
                            rxOnly <= iData[CFG_RX_ONLY];
                            doneIe <= iData[CFG_DONE_IE];
                            chan   <= iData[CFG_CHAN_LSB +: 4];
                            count  <= iData[CFG_COUNT_LSB +: 8];
                            step   <= iData[CFG_STEP_LSB +: 12];
                            if (iData[CFG_GO_SINGLE] || iData[CFG_GO_BLOCK]) begin
                                state     <= LOAD;
                                isSingle  <= iData[CFG_GO_SINGLE];
                                wordsLeft <= iData[CFG_GO_SINGLE] ? 8'd0 : iData[CFG_COUNT_LSB +: 8];
                                mosiXPtr  <= mosiPtr;
                                misoXPtr  <= misoPtr;
                            end
                        end
                    end
                    ADDR_DIRECT_MOSI: directMosi <= iData;
                    ADDR_MOSI_PTR:    mosiPtr <= iData[PW-1:0];
                    ADDR_MOSI_DATA:   mosiPtr <= mosiPtr + 1'b1;
                    ADDR_MISO_PTR:    misoPtr <= iData[PW-1:0];
                    ADDR_STATUS: begin
                        if (iData[1]) done  <= 1'b0;
                        if (iData[2]) error <= 1'b0;
                    end
`ifdef SYSX_IRQ_EN
                    ADDR_IRQ_MASK:    irqMask <= iData[CHANNELS-1:0];
`endif
                    default: ;
                endcase
            end

            case (state)
                LOAD: begin
                    txWord    <= isSingle ? directMosi : mosiRdata;
                    divCnt    <= '0;
                    phaseHigh <= 1'b0;
                    beatCnt   <= '0;
                    busClk    <= 1'b0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (phaseHigh && divCnt == '0) rxWord <= 32'(rxShifted >> LANE_W);
                    if (divCnt == step) begin
                        divCnt <= '0;
                        if (!phaseHigh) begin
                            phaseHigh <= 1'b1;
                            busClk    <= 1'b1;
                        end else begin
                            phaseHigh <= 1'b0;
                            txWord    <= txWord >> LANE_W;
                            if (beatCnt == 6'(BEATS - 1)) begin
                                busClk <= 1'b1;
                                state  <= STORE;
                            end else begin
                                busClk  <= 1'b0;
                                beatCnt <= beatCnt + 1'b1;
                            end
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                STORE: begin
                    if (isSingle) directMiso <= rxWord;
                    mosiXPtr <= mosiXPtr + 1'b1;
                    misoXPtr <= misoXPtr + 1'b1;
                    if (wordsLeft != '0) begin
                        wordsLeft <= wordsLeft - 1'b1;
                        state     <= LOAD;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysx_master_v2.sv
// tb/tb_sysx_master_v2.sv - directed self-checking bench for sysx_master_v2 (LANE_W=8, DEPTH=4, CHANNELS=4)
module tb_sysx_master_v2;

`ifdef SYSX_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        iClock = 1'b0;
    logic        iReset;
    logic [3:0]  iAddress;
    logic        iWrite, iEnable;
    logic [31:0] iData;
    logic [31:0] oData;
    logic        oInterrupt, oBusClock;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO = 8'h00;
    logic [3:0]  oBusSelect;
    logic [3:0]  iBusInterrupt;

    int checks = 0;
    int errors = 0;

    logic [7:0] echoBytes [16];
    logic [7:0] mosiSeen [16];
    int         beatIdx = 0;
    wire        allDeselected = &oBusSelect;

    sysx_master_v2 #(.LANE_W(8), .DEPTH(4), .CHANNELS(4)) dut (
        .iClock(iClock), .iReset(iReset), .iAddress(iAddress), .iWrite(iWrite),
        .iEnable(iEnable), .iData(iData), .oData(oData), .oInterrupt(oInterrupt),
        .oBusClock(oBusClock), .oBusMOSI(oBusMOSI), .iBusMISO(iBusMISO),
        .oBusSelect(oBusSelect), .iBusInterrupt(iBusInterrupt)
    );

    always #5 iClock = ~iClock;

    // Peripheral model: presents the next echo byte at the start of each beat.
    always @(negedge oBusClock or posedge allDeselected) begin
        if (allDeselected) begin
            beatIdx = 0;
        end else begin
            iBusMISO = echoBytes[beatIdx % 16];
            beatIdx  = beatIdx + 1;
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  addr;
        logic        doWrite;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        iAddress = a; iData = d; iWrite = 1'b1; iEnable = 1'b1;
        @(posedge iClock); #1;
        iEnable = 1'b0; iWrite = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        iAddress = a; iWrite = 1'b0; iEnable = 1'b1;
        @(posedge iClock); #1;
        iEnable = 1'b0;
        @(negedge iClock);
        d = oData;
        @(posedge iClock); #1;
    endtask

    task automatic rdCheck(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic monitor(input int maxCycles, output int selCycles, output logic [3:0] selVal,
                           output logic finished);
        logic prevClk = 1'b1;
        logic seen = 1'b0;
        int   k = 0;
        selCycles = 0; selVal = 4'hF; finished = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge iClock);
            if (oBusSelect != 4'hF) begin
                selCycles++;
                selVal = oBusSelect;
                seen   = 1'b1;
            end
            if (oBusClock && !prevClk && k < 16) begin
                mosiSeen[k] = oBusMOSI;
                k++;
            end
            prevClk = oBusClock;
            if (seen && oBusSelect == 4'hF) begin
                finished = 1'b1;
                break;
            end
        end
        @(posedge iClock); #1;
    endtask

    initial begin
        int          selCycles;
        logic [3:0]  selVal;
        logic        finished;
        logic [31:0] d;

        vecs[0] = '{"direct_mosi", 4'd1,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{"mosi_ptr_mask", 4'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[2] = '{"miso_ptr_mask", 4'd5, 1'b1, 32'h0000_0006, 32'h0000_0002};
        vecs[3] = '{"irq_mask", 4'd8, 1'b1, 32'h0000_00FF, IRQ ? 32'h0000_000F : 32'h0};
        vecs[4] = '{"bad_addr9", 4'd9, 1'b1, 32'h1234_5678, 32'h0BAD_C0DE};
        vecs[5] = '{"bad_addr15", 4'd15, 1'b0, 32'h0, 32'h0BAD_C0DE};
        vecs[6] = '{"config_rw", 4'd0, 1'b1, 32'h0001_0124, 32'h0001_0124};
        vecs[7] = '{"direct_miso_rst", 4'd2, 1'b0, 32'h0, 32'h0};
        vecs[8] = '{"status_idle", 4'd7, 1'b0, 32'h0, 32'h0};

        for (int i = 0; i < 16; i++) echoBytes[i] = 8'h00;
        echoBytes[0] = 8'hA5; echoBytes[1] = 8'h5A; echoBytes[2] = 8'hC3; echoBytes[3] = 8'h3C;

        iReset = 1'b0; iAddress = '0; iWrite = 1'b0; iEnable = 1'b0; iData = '0; iBusInterrupt = '0;
        repeat (2) @(posedge iClock);
        @(negedge iClock);
        check("rst_oData", oData, 32'h0);
        check("rst_select", 32'(oBusSelect), 32'hF);
        check("rst_busclk", 32'(oBusClock), 32'h1);
        check("rst_irq", 32'(oInterrupt), 32'h0);
        check("rst_mosi", 32'(oBusMOSI), 32'h0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(posedge iClock); #1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].doWrite) wr(vecs[i].addr, vecs[i].wdata);
            rdCheck(vecs[i].name, vecs[i].addr, vecs[i].expRead);
        end

        // Single transfer, channel 2, STEP=1.
        wr(4'd1, 32'h1122_3344);
        wr(4'd0, 32'h0001_0021);
        monitor(60, selCycles, selVal, finished);
        check("single_finished", 32'(finished), 32'h1);
        check("single_sel_cycles", selCycles, 18);
        check("single_sel_value", 32'(selVal), 32'hB);
        check("single_mosi0", 32'(mosiSeen[0]), 32'h44);
        check("single_mosi1", 32'(mosiSeen[1]), 32'h33);
        check("single_mosi2", 32'(mosiSeen[2]), 32'h22);
        check("single_mosi3", 32'(mosiSeen[3]), 32'h11);
        rdCheck("single_miso", 4'd2, 32'h3CC3_5AA5);
        rdCheck("single_status", 4'd7, 32'h0000_0002);
        rdCheck("single_config_goclr", 4'd0, 32'h0001_0020);

        // Busy guard: a CONFIG write mid-transfer is dropped and flags error.
        wr(4'd7, 32'h2);
        wr(4'd0, 32'h0001_0021);
        repeat (3) @(posedge iClock); #1;
        wr(4'd0, 32'h0000_00F1);
        rdCheck("guard_status_busy", 4'd7, 32'h0000_0005);
        monitor(60, selCycles, selVal, finished);
        check("guard_finished", 32'(finished), 32'h1);
        rdCheck("guard_miso", 4'd2, 32'h3CC3_5AA5);
        rdCheck("guard_config", 4'd0, 32'h0001_0020);
        rdCheck("guard_status_done", 4'd7, 32'h0000_0006);
        wr(4'd7, 32'h4);
        rdCheck("guard_status_errclr", 4'd7, 32'h0000_0002);

        // Auto-increment MOSI port with wrap, then a 3-word block from pointer 3.
        wr(4'd3, 32'h0);
        wr(4'd4, 32'h1); wr(4'd4, 32'h2); wr(4'd4, 32'h3);
        rdCheck("mosi_ptr_after3", 4'd3, 32'h3);
        wr(4'd4, 32'h44);
        rdCheck("mosi_ptr_wrap", 4'd3, 32'h0);
        wr(4'd3, 32'h3);
        rdCheck("mosi_data_read", 4'd4, 32'h44);
        rdCheck("mosi_ptr_noinc", 4'd3, 32'h3);
        wr(4'd5, 32'h3);
        for (int i = 0; i < 12; i++) echoBytes[i] = 8'((i / 4 + 1) * 16 + i % 4);
        wr(4'd0, 32'h0001_0202);
        monitor(200, selCycles, selVal, finished);
        check("block_finished", 32'(finished), 32'h1);
        check("block_sel_cycles", selCycles, 54);
        check("block_sel_value", 32'(selVal), 32'hE);
        check("block_word0", 32'(mosiSeen[0]), 32'h44);
        check("block_word1", 32'(mosiSeen[4]), 32'h01);
        check("block_word2", 32'(mosiSeen[8]), 32'h02);
        rdCheck("block_host_mosi_ptr", 4'd3, 32'h3);
        rdCheck("block_host_miso_ptr", 4'd5, 32'h3);
        rdCheck("miso_data_p3", 4'd6, 32'h1312_1110);
        rdCheck("miso_data_p0", 4'd6, 32'h2322_2120);
        rdCheck("miso_data_p1", 4'd6, 32'h3332_3130);
        rdCheck("miso_ptr_after", 4'd5, 32'h2);
        wr(4'd5, 32'h0);
        rdCheck("miso_seq0", 4'd6, 32'h2322_2120);
        rdCheck("miso_seq1", 4'd6, 32'h3332_3130);
        rd(4'd6, d);
        rdCheck("miso_ptr_three", 4'd5, 32'h3);

        // Interrupts.
        wr(4'd7, 32'h2);
        wr(4'd8, 32'h4);
        iBusInterrupt = 4'b0100;
        @(negedge iClock);
        check("irq_periph2", 32'(oInterrupt), 32'(IRQ));
        @(posedge iClock); #1;
        iBusInterrupt = 4'b0010;
        @(negedge iClock);
        check("irq_periph1_masked", 32'(oInterrupt), 32'h0);
        @(posedge iClock); #1;
        rdCheck("status_irq_bits", 4'd7, IRQ ? 32'h0000_0200 : 32'h0);
        iBusInterrupt = 4'b0000;
        wr(4'd0, 32'h0000_0009);
        monitor(40, selCycles, selVal, finished);
        check("step0_finished", 32'(finished), 32'h1);
        check("step0_sel_cycles", selCycles, 10);
        check("irq_done", 32'(oInterrupt), 32'(IRQ));
        wr(4'd7, 32'h2);
        @(negedge iClock);
        check("irq_done_clr", 32'(oInterrupt), 32'h0);
        @(posedge iClock); #1;

        // Asynchronous reset during beat 2.
        for (int i = 0; i < 4; i++) echoBytes[i] = 8'h77;
        rdCheck("pre_reset_read", 4'd1, 32'h1122_3344);
        wr(4'd0, 32'h0001_0021);
        repeat (10) @(posedge iClock); #1;
        check("mid_sel_active", 32'(oBusSelect), 32'hB);
        iReset = 1'b0;
        #1;
        check("reset_sel", 32'(oBusSelect), 32'hF);
        check("reset_busclk", 32'(oBusClock), 32'h1);
        check("reset_odata", oData, 32'h0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        rdCheck("post_reset_status", 4'd7, 32'h0);
        rdCheck("post_reset_config", 4'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
